// File: rtl/mul_sched_if.sv
// Request/response bundle between the requesting datapaths and the shared multiplier scheduler.
interface mul_sched_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 2
);
  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_multiplier;
  logic [N_REQ*WIDTH-1:0] req_multiplicand;
  logic [N_REQ-1:0]       req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IW-1:0]          resp_id;
  logic [2*WIDTH-1:0]     resp_result;
  logic                   busy;

  modport master (
    output req_valid, req_multiplier, req_multiplicand, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, busy
  );

  modport slave (
    input  req_valid, req_multiplier, req_multiplicand, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, busy
  );
endinterface

// File: rtl/mul_sched.sv
// Round-robin front end for one iterative shift-add multiplier shared by N_REQ requesters.
// One multiplier bit is consumed per clock; the product is returned tagged with the owner's index.
module mul_sched #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 2
) (
  input  logic       clock,
  input  logic       reset,
  mul_sched_if.slave bus
);
  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [IW-1:0]      last;
  logic [IW-1:0]      gnt;
  logic               gnt_ok;
  logic [IW:0]        idx;
  logic [2**IW-1:0]   vld_ext;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  assign vld_ext = (2**IW)'(bus.req_valid);

  // Walk from the farthest candidate to the nearest, so the nearest valid one after 'last' wins.
  always_comb begin
    gnt    = last;
    gnt_ok = 1'b0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = {1'b0, last} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (vld_ext[idx[IW-1:0]]) begin
        gnt    = idx[IW-1:0];
        gnt_ok = 1'b1;
      end
    end
  end

  assign bus.req_ready   = (state == IDLE && gnt_ok && !reset) ? (N_REQ'(1) << gnt) : '0;
  assign bus.resp_result = acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last           <= IW'(N_REQ - 1);
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.busy       <= 1'b0;
      acc            <= '0;
      mplier         <= '0;
      mcand          <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_ok) begin
          mplier      <= bus.req_multiplier[gnt*WIDTH +: WIDTH];
          mcand       <= {{WIDTH{1'b0}}, bus.req_multiplicand[gnt*WIDTH +: WIDTH]};
          acc         <= '0;
          cnt         <= '0;
          last        <= gnt;
          bus.resp_id <= gnt;
          bus.busy    <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Fixed WIDTH iterations, no early exit on zero operands.
          if (cnt == CW'(WIDTH - 1)) begin
            state          <= DONE;
            bus.resp_valid <= 1'b1;
          end
        end
        DONE: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed scenarios plus random traffic, checked against a transaction-level model.
module tb_mul_sched;
  localparam int W  = 8;
  localparam int N  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mul_sched_if #(.WIDTH(W), .N_REQ(N)) bus();
  mul_sched #(.WIDTH(W), .N_REQ(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;
  always @(posedge clock) edge_n++;

  // stimulus state
  logic [N-1:0]  v;
  logic          rr;
  int unsigned   ma[];
  int unsigned   mc[];

  // reference model state
  bit            m_idle;
  int            m_last;
  int            acc_edge;
  int            q_id[$];
  longint unsigned q_prod[$];
  int            gnt_log[$];
  longint unsigned last_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle of model evaluation, sampled well after the falling edge.
  task automatic tick();
    int g;
    int j;
    logic [N-1:0] sh;
    bit exp_rv;
    #1;
    if (m_idle && (|v)) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        j  = (m_last + k) % N;
        sh = v >> j;
        if (g < 0 && sh[0]) g = j;
      end
      chk("grant", 64'(bus.req_ready), 64'(1) << g);
      q_id.push_back(g);
      q_prod.push_back(64'(ma[g]) * 64'(mc[g]));
      gnt_log.push_back(g);
      m_last   = g;
      m_idle   = 1'b0;
      acc_edge = edge_n + 1;
    end else begin
      chk("no_grant", 64'(bus.req_ready), 64'(0));
    end
    chk("busy", 64'(bus.busy), 64'(!m_idle && edge_n >= acc_edge));
    exp_rv = !m_idle && (edge_n >= acc_edge + W);
    chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    if (exp_rv && q_id.size() > 0) begin
      chk("resp_id", 64'(bus.resp_id), 64'(q_id[0]));
      chk("resp_result", 64'(bus.resp_result), q_prod[0]);
      if (rr) begin
        last_res = 64'(bus.resp_result);
        void'(q_id.pop_front());
        void'(q_prod.pop_front());
        m_idle = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    bus.req_valid  = v;
    bus.resp_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_multiplier[i*W +: W]   = W'(ma[i]);
      bus.req_multiplicand[i*W +: W] = W'(mc[i]);
    end
    tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    v             = '1;
    bus.req_valid = '1;
    #1 chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clock);
    reset         = 1'b0;
    v             = '0;
    bus.req_valid = '0;
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_resp_result", 64'(bus.resp_result), 64'(0));
    chk("rst_resp_id", 64'(bus.resp_id), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    q_id.delete();
    q_prod.delete();
    m_idle = 1'b1;
    m_last = N - 1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!m_idle && t < 80) begin
      cyc();
      t++;
    end
    if (!m_idle) chk("drain_timeout", 64'(1), 64'(0));
  endtask

  // Issue one op; operands are zeroed right after acceptance to show they are not re-read.
  task automatic run_op(input int id, input int unsigned a, input int unsigned b,
                        input longint unsigned exp);
    int t;
    v = N'(1) << id;
    ma[id] = a;
    mc[id] = b;
    t = 0;
    do begin
      cyc();
      t++;
    end while (m_idle && t < 40);
    if (m_idle) chk("grant_timeout", 64'(1), 64'(0));
    v = '0;
    ma[id] = 0;
    mc[id] = 0;
    drain();
    chk("product", last_res, exp);
  endtask

  initial begin
    ma = new[N];
    mc = new[N];
    v = '0;
    rr = 1'b1;
    m_idle = 1'b1;
    m_last = N - 1;
    acc_edge = 0;
    last_res = 0;
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    bus.req_multiplier = '0;
    bus.req_multiplicand = '0;

    do_reset();
    run_op(0, 13, 11, 143);
    run_op(0, 255, 255, 64'hFE01);
    run_op(1, 0, 200, 0);
    run_op(0, 1, 255, 255);
    run_op(1, 128, 2, 256);
    run_op(0, 6, 7, 42);

    // round robin with both requesters continuously valid from reset
    do_reset();
    ma[0] = 3; mc[0] = 5; ma[1] = 7; mc[1] = 9;
    v = '1;
    gnt_log.delete();
    repeat (4 * (W + 2) + 2) cyc();
    chk("rr_count", 64'(gnt_log.size() >= 4), 64'(1));
    if (gnt_log.size() >= 4) begin
      chk("rr_g0", 64'(gnt_log[0]), 64'(0));
      chk("rr_g1", 64'(gnt_log[1]), 64'(1));
      chk("rr_g2", 64'(gnt_log[2]), 64'(0));
      chk("rr_g3", 64'(gnt_log[3]), 64'(1));
    end
    v = '0;
    drain();

    // backpressure: response held 20 cycles while both requesters wait
    rr = 1'b0;
    v = 2'b01; ma[0] = 9; mc[0] = 9; ma[1] = 4; mc[1] = 5;
    repeat (W + 2) cyc();
    v = '1;
    repeat (20) cyc();
    rr = 1'b1;
    gnt_log.delete();
    cyc();
    cyc();
    chk("bp_regrant", 64'(gnt_log.size() == 1 && gnt_log[0] == 1), 64'(1));
    v = '0;
    drain();

    // reset during RUN step 4 discards the product
    v = 2'b01; ma[0] = 20; mc[0] = 20;
    cyc();
    v = '0;
    repeat (4) cyc();
    do_reset();
    v = '1; ma[0] = 20; mc[0] = 20; ma[1] = 3; mc[1] = 3;
    gnt_log.delete();
    cyc();
    chk("rst_regrant", 64'(gnt_log.size() == 1 && gnt_log[0] == 0), 64'(1));
    v = '0;
    drain();
    chk("rst_product", last_res, 64'd400);

    // random traffic
    repeat (1500) begin
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ma[i] = $urandom_range(0, (1 << W) - 1);
        mc[i] = $urandom_range(0, (1 << W) - 1);
      end
      rr = ($urandom % 4) != 0;
      cyc();
    end
    v = '0;
    rr = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
